id_ex_pipe_reg: RTL and testbench

// ID/EX pipeline register for the pipelined OTTER core. Latches decoder control outputs and operands each cycle for the EX stage.

---
 rtl/id_ex_pipe_reg.sv | 168 ++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: latches decoded control and operands for EX, detects load-use hazards, counts stall bubbles.
// Latency: one cycle from ID_* inputs to EX_* outputs; LOAD_USE_STALL is combinational in the same cycle.
// Backpressure: HOLD freezes every register; LOAD_USE_STALL asks IF and IF/ID to hold while one bubble enters EX.
//
// Ports:
//    CLK, RST                   clock and asynchronous active-high reset
//    FLUSH, HOLD                kill the incoming instruction / freeze the stage
//    ID_*                       instruction, operands and decoder controls from ID
//    EX_*                       registered copies presented to EX
//    LOAD_USE_STALL             hazard request to upstream stages
//    STALL_CNT                  saturating count of load-use bubbles inserted
module id_ex_pipe_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             FLUSH,
   input  logic             HOLD,
   input  logic             ID_VALID,
   input  logic [XLEN-1:0]  ID_PC,
   input  logic [XLEN-1:0]  ID_IR,
   input  logic [XLEN-1:0]  ID_RS1_DATA,
   input  logic [XLEN-1:0]  ID_RS2_DATA,
   input  logic             ID_REG_WRITE,
   input  logic             ID_MEM_WE2,
   input  logic             ID_MEM_RDEN2,
   input  logic [3:0]       ID_ALU_FUN,
   input  logic             ID_ALU_SRCA,
   input  logic [1:0]       ID_ALU_SRCB,
   input  logic [1:0]       ID_RF_WR_SEL,
   output logic             EX_VALID,
   output logic [XLEN-1:0]  EX_PC,
   output logic [XLEN-1:0]  EX_IR,
   output logic [XLEN-1:0]  EX_RS1_DATA,
   output logic [XLEN-1:0]  EX_RS2_DATA,
   output logic             EX_REG_WRITE,
   output logic             EX_MEM_WE2,
   output logic             EX_MEM_RDEN2,
   output logic [3:0]       EX_ALU_FUN,
   output logic             EX_ALU_SRCA,
   output logic [1:0]       EX_ALU_SRCB,
   output logic [1:0]       EX_RF_WR_SEL,
   output logic             LOAD_USE_STALL,
   output logic [CNT_W-1:0] STALL_CNT
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic       reg_write;
      logic       mem_we2;
      logic       mem_rden2;
      logic [3:0] alu_fun;
      logic       alu_srca;
      logic [1:0] alu_srcb;
      logic [1:0] rf_wr_sel;
   } ctrl_t;

   ctrl_t             id_ctrl;
   ctrl_t             ctrl_d, ctrl_q;
   logic              ex_valid_d, ex_valid_q;
   logic [XLEN-1:0]   ex_pc_d, ex_pc_q;
   logic [XLEN-1:0]   ex_ir_d, ex_ir_q;
   logic [XLEN-1:0]   ex_rs1_d, ex_rs1_q;
   logic [XLEN-1:0]   ex_rs2_d, ex_rs2_q;
   logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

   logic [4:0] rd_ex, rs1_id, rs2_id;
   logic [6:0] opcode_id;
   logic       use1, use2, load_use_stall;

   assign id_ctrl = '{reg_write: ID_REG_WRITE, mem_we2: ID_MEM_WE2, mem_rden2: ID_MEM_RDEN2,
                      alu_fun: ID_ALU_FUN, alu_srca: ID_ALU_SRCA, alu_srcb: ID_ALU_SRCB,
                      rf_wr_sel: ID_RF_WR_SEL};

   assign rd_ex     = ex_ir_q[11:7];
   assign rs1_id    = ID_IR[19:15];
   assign rs2_id    = ID_IR[24:20];
   assign opcode_id = ID_IR[6:0];

   // U-type and JAL carry immediate bits in the rs1 field; only R/S/B formats read rs2.
   assign use1 = !((opcode_id == OP_LUI) || (opcode_id == OP_AUIPC) || (opcode_id == OP_JAL));
   assign use2 = (opcode_id == OP_RTYPE) || (opcode_id == OP_STORE) || (opcode_id == OP_BRANCH);

   // Not gated by HOLD, so upstream keeps stalling while memory is busy.
   assign load_use_stall = ex_valid_q && ctrl_q.mem_rden2 && (rd_ex != 5'd0) && ID_VALID &&
                           ((use1 && (rs1_id == rd_ex)) || (use2 && (rs2_id == rd_ex)));

   always_comb begin
      ex_valid_d  = ex_valid_q;
      ex_pc_d     = ex_pc_q;
      ex_ir_d     = ex_ir_q;
      ex_rs1_d    = ex_rs1_q;
      ex_rs2_d    = ex_rs2_q;
      ctrl_d      = ctrl_q;
      stall_cnt_d = stall_cnt_q;
      if (FLUSH) begin
         ex_valid_d = 1'b0;
         ex_pc_d    = '0;
         ex_ir_d    = '0;
         ex_rs1_d   = '0;
         ex_rs2_d   = '0;
         ctrl_d     = '0;
      end else if (HOLD) begin
         // everything keeps its value
      end else if (load_use_stall) begin
         ex_valid_d = 1'b0;
         ex_pc_d    = '0;
         ex_ir_d    = '0;
         ex_rs1_d   = '0;
         ex_rs2_d   = '0;
         ctrl_d     = '0;
         if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end else begin
         ex_valid_d = ID_VALID;
         ex_pc_d    = ID_PC;
         ex_ir_d    = ID_IR;
         ex_rs1_d   = ID_RS1_DATA;
         ex_rs2_d   = ID_RS2_DATA;
         // An invalid slot must never write the register file or memory.
         ctrl_d     = ID_VALID ? id_ctrl : '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_valid_q  <= 1'b0;
         ex_pc_q     <= '0;
         ex_ir_q     <= '0;
         ex_rs1_q    <= '0;
         ex_rs2_q    <= '0;
         ctrl_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_pc_q     <= ex_pc_d;
         ex_ir_q     <= ex_ir_d;
         ex_rs1_q    <= ex_rs1_d;
         ex_rs2_q    <= ex_rs2_d;
         ctrl_q      <= ctrl_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign EX_VALID       = ex_valid_q;
   assign EX_PC          = ex_pc_q;
   assign EX_IR          = ex_ir_q;
   assign EX_RS1_DATA    = ex_rs1_q;
   assign EX_RS2_DATA    = ex_rs2_q;
   assign EX_REG_WRITE   = ctrl_q.reg_write;
   assign EX_MEM_WE2     = ctrl_q.mem_we2;
   assign EX_MEM_RDEN2   = ctrl_q.mem_rden2;
   assign EX_ALU_FUN     = ctrl_q.alu_fun;
   assign EX_ALU_SRCA    = ctrl_q.alu_srca;
   assign EX_ALU_SRCB    = ctrl_q.alu_srcb;
   assign EX_RF_WR_SEL   = ctrl_q.rf_wr_sel;
   assign LOAD_USE_STALL = load_use_stall;
   assign STALL_CNT      = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

   logic        CLK = 1'b0;
   logic        RST, FLUSH, HOLD, ID_VALID;
   logic [31:0] ID_PC, ID_IR, ID_RS1_DATA, ID_RS2_DATA;
   logic        ID_REG_WRITE, ID_MEM_WE2, ID_MEM_RDEN2, ID_ALU_SRCA;
   logic [3:0]  ID_ALU_FUN;
   logic [1:0]  ID_ALU_SRCB, ID_RF_WR_SEL;

   logic        EX_VALID, EX_REG_WRITE, EX_MEM_WE2, EX_MEM_RDEN2, EX_ALU_SRCA, LOAD_USE_STALL;
   logic [31:0] EX_PC, EX_IR, EX_RS1_DATA, EX_RS2_DATA;
   logic [3:0]  EX_ALU_FUN;
   logic [1:0]  EX_ALU_SRCB, EX_RF_WR_SEL;
   logic [15:0] STALL_CNT;

   logic        s_valid, s_reg_write, s_mem_we2, s_mem_rden2, s_alu_srca, s_lus;
   logic [31:0] s_pc, s_ir, s_rs1, s_rs2;
   logic [3:0]  s_alu_fun;
   logic [1:0]  s_alu_srcb, s_rf_wr_sel;
   logic [1:0]  s_stall_cnt;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   id_ex_pipe_reg #(.XLEN(32), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .HOLD(HOLD), .ID_VALID(ID_VALID),
      .ID_PC(ID_PC), .ID_IR(ID_IR), .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA),
      .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_WE2(ID_MEM_WE2), .ID_MEM_RDEN2(ID_MEM_RDEN2),
      .ID_ALU_FUN(ID_ALU_FUN), .ID_ALU_SRCA(ID_ALU_SRCA), .ID_ALU_SRCB(ID_ALU_SRCB),
      .ID_RF_WR_SEL(ID_RF_WR_SEL),
      .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_IR(EX_IR), .EX_RS1_DATA(EX_RS1_DATA),
      .EX_RS2_DATA(EX_RS2_DATA), .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_WE2(EX_MEM_WE2),
      .EX_MEM_RDEN2(EX_MEM_RDEN2), .EX_ALU_FUN(EX_ALU_FUN), .EX_ALU_SRCA(EX_ALU_SRCA),
      .EX_ALU_SRCB(EX_ALU_SRCB), .EX_RF_WR_SEL(EX_RF_WR_SEL),
      .LOAD_USE_STALL(LOAD_USE_STALL), .STALL_CNT(STALL_CNT)
   );

   // Narrow-counter instance sharing all inputs, used for the saturation check.
   id_ex_pipe_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .HOLD(HOLD), .ID_VALID(ID_VALID),
      .ID_PC(ID_PC), .ID_IR(ID_IR), .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA),
      .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_WE2(ID_MEM_WE2), .ID_MEM_RDEN2(ID_MEM_RDEN2),
      .ID_ALU_FUN(ID_ALU_FUN), .ID_ALU_SRCA(ID_ALU_SRCA), .ID_ALU_SRCB(ID_ALU_SRCB),
      .ID_RF_WR_SEL(ID_RF_WR_SEL),
      .EX_VALID(s_valid), .EX_PC(s_pc), .EX_IR(s_ir), .EX_RS1_DATA(s_rs1),
      .EX_RS2_DATA(s_rs2), .EX_REG_WRITE(s_reg_write), .EX_MEM_WE2(s_mem_we2),
      .EX_MEM_RDEN2(s_mem_rden2), .EX_ALU_FUN(s_alu_fun), .EX_ALU_SRCA(s_alu_srca),
      .EX_ALU_SRCB(s_alu_srcb), .EX_RF_WR_SEL(s_rf_wr_sel),
      .LOAD_USE_STALL(s_lus), .STALL_CNT(s_stall_cnt)
   );

   function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b0, rd, op};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic rw, input logic we, input logic rd, input logic [3:0] fun,
                         input logic sa, input logic [1:0] sb, input logic [1:0] ws);
      ID_VALID = v; ID_PC = pc; ID_IR = ir; ID_RS1_DATA = d1; ID_RS2_DATA = d2;
      ID_REG_WRITE = rw; ID_MEM_WE2 = we; ID_MEM_RDEN2 = rd; ID_ALU_FUN = fun;
      ID_ALU_SRCA = sa; ID_ALU_SRCB = sb; ID_RF_WR_SEL = ws;
   endtask

   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_S    = 7'b0100011;

   logic [31:0] ir_add, ir_lw5, ir_lw0, ir_use5, ir_use0, ir_lui5, ir_addi, ir_sw5;

   initial begin
      ir_add  = mk_ir(OP_R, 5'd3, 5'd1, 5'd2);
      ir_lw5  = mk_ir(OP_LOAD, 5'd5, 5'd1, 5'd0);
      ir_lw0  = mk_ir(OP_LOAD, 5'd0, 5'd1, 5'd0);
      ir_use5 = mk_ir(OP_R, 5'd6, 5'd5, 5'd1);
      ir_use0 = mk_ir(OP_R, 5'd6, 5'd0, 5'd0);
      ir_lui5 = mk_ir(OP_LUI, 5'd5, 5'd5, 5'd5);
      ir_addi = mk_ir(OP_I, 5'd7, 5'd6, 5'd5);
      ir_sw5  = mk_ir(OP_S, 5'd0, 5'd2, 5'd5);

      RST = 1'b1; FLUSH = 1'b0; HOLD = 1'b0;
      set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0);
      #3;
      check("rst_valid", EX_VALID, 0);
      check("rst_cnt", STALL_CNT, 0);
      check("rst_pc", EX_PC, 0);
      check("rst_lus", LOAD_USE_STALL, 0);
      @(negedge CLK);
      RST = 1'b0;

      // Normal flow: ADD x3,x1,x2
      set_id(1'b1, 32'h100, ir_add, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd3);
      #1 check("add_lus", LOAD_USE_STALL, 0);
      tick();
      check("add_valid", EX_VALID, 1);
      check("add_fun", EX_ALU_FUN, 4'b0000);
      check("add_rs1", EX_RS1_DATA, 5);
      check("add_rs2", EX_RS2_DATA, 7);
      check("add_rw", EX_REG_WRITE, 1);
      check("add_wrsel", EX_RF_WR_SEL, 3);
      check("add_pc", EX_PC, 32'h100);
      check("add_ir", EX_IR, ir_add);

      // Asynchronous reset with the ADD sitting in EX
      #1 RST = 1'b1;
      #1;
      check("arst_valid", EX_VALID, 0);
      check("arst_rw", EX_REG_WRITE, 0);
      check("arst_rs1", EX_RS1_DATA, 0);
      check("arst_ir", EX_IR, 0);
      #1 RST = 1'b0;

      // Invalid slot loads: control must not leak through
      set_id(1'b0, 32'h104, ir_add, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b1, 2'd1, 2'd3);
      tick();
      check("inv_valid", EX_VALID, 0);
      check("inv_rw", EX_REG_WRITE, 0);
      check("inv_we", EX_MEM_WE2, 0);
      check("inv_fun", EX_ALU_FUN, 0);

      // Load-use: LW x5 then ADD x6,x5,x1
      set_id(1'b1, 32'h200, ir_lw5, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 2'd2);
      tick();
      check("lw_rden", EX_MEM_RDEN2, 1);
      check("lw_srcb", EX_ALU_SRCB, 1);
      set_id(1'b1, 32'h204, ir_use5, 32'd9, 32'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd3);
      #1 check("lu_stall", LOAD_USE_STALL, 1);
      tick();
      check("lu_bub_valid", EX_VALID, 0);
      check("lu_bub_rw", EX_REG_WRITE, 0);
      check("lu_bub_rden", EX_MEM_RDEN2, 0);
      check("lu_cnt", STALL_CNT, 1);
      check("lu_drop", LOAD_USE_STALL, 0);
      tick();
      check("lu_add_valid", EX_VALID, 1);
      check("lu_add_ir", EX_IR, ir_use5);
      check("lu_cnt2", STALL_CNT, 1);

      // No false hazards
      set_id(1'b1, 32'h300, ir_lw0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 2'd2);
      tick();
      set_id(1'b1, 32'h304, ir_use0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd3);
      #1 check("x0_nostall", LOAD_USE_STALL, 0);
      set_id(1'b1, 32'h308, ir_lw5, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 2'd2);
      tick();
      set_id(1'b1, 32'h30c, ir_lui5, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0, 2'd2, 2'd3);
      #1 check("lui_nostall", LOAD_USE_STALL, 0);
      set_id(1'b1, 32'h30c, ir_addi, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 2'd3);
      #1 check("addi_nostall", LOAD_USE_STALL, 0);
      set_id(1'b1, 32'h30c, ir_sw5, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 2'd0);
      #1 check("sw_stall", LOAD_USE_STALL, 1);

      // HOLD with a hazard: EX frozen, stall still reported, no count
      HOLD = 1'b1;
      tick();
      check("hold_ir", EX_IR, ir_lw5);
      check("hold_valid", EX_VALID, 1);
      check("hold_lus", LOAD_USE_STALL, 1);
      check("hold_cnt", STALL_CNT, 1);

      // FLUSH and HOLD together: bubble
      FLUSH = 1'b1;
      tick();
      check("fh_valid", EX_VALID, 0);
      check("fh_rden", EX_MEM_RDEN2, 0);
      check("fh_pc", EX_PC, 0);
      check("fh_cnt", STALL_CNT, 1);

      // FLUSH with a hazard: flush wins, no count
      FLUSH = 1'b0; HOLD = 1'b0;
      set_id(1'b1, 32'h400, ir_lw5, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 2'd2);
      tick();
      set_id(1'b1, 32'h404, ir_sw5, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 2'd0);
      FLUSH = 1'b1;
      #1 check("fl_lus", LOAD_USE_STALL, 1);
      tick();
      check("fl_valid", EX_VALID, 0);
      check("fl_cnt", STALL_CNT, 1);
      FLUSH = 1'b0;

      // Five more load-use events; narrow counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         set_id(1'b1, 32'h500, ir_lw5, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 2'd2);
         tick();
         set_id(1'b1, 32'h504, ir_use5, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd3);
         tick();
         if (i == 1) check("sat_reach", s_stall_cnt, 3);
      end
      check("sat_cnt", s_stall_cnt, 3);
      check("wide_cnt", STALL_CNT, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
